// File: rtl/freq_pkg.sv
// Shared types and defaults for the frequency/duty-cycle meter.
package freq_pkg;

    localparam int CNT_W_DEF = 26;

    typedef enum logic {
        WAIT_FIRST = 1'b0,
        MEASURE    = 1'b1
    } state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous input, plus a delay stage for rising-edge detection.
module sync_edge_det (
    input  logic clk_in,
    input  logic reset_n,
    input  logic sig_in,
    output logic s,
    output logic rise
);

    logic r_meta;
    logic r_sync;
    logic r_sync_d;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_sync_d <= 1'b0;
        end else begin
            r_meta   <= sig_in;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
        end
    end

    assign s    = r_sync;
    assign rise = r_sync & ~r_sync_d;

endmodule

// File: rtl/freq_meter.sv
// Measures period and high time of a slow square wave in clk_in cycles, one result per period,
// with a loss-of-signal flag when no rising edge arrives within TIMEOUT_CYC cycles.
module freq_meter
    import freq_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             stuck,
    output logic             level,
    output state_t           dbg_state
);

    localparam logic [CNT_W-1:0] L_TIMEOUT = CNT_W'(TIMEOUT_CYC);

    logic             w_s;
    logic             w_rise;
    logic             w_capture;
    logic             w_timeout;
    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hi_cnt;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high_time;
    logic             r_meas_valid;
    logic             r_stuck;

    sync_edge_det u_sync (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .sig_in  (sig_in),
        .s       (w_s),
        .rise    (w_rise)
    );

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) r_state <= WAIT_FIRST;
        else          r_state <= w_next;
    end

    // Priority: enable low, then rise, then timeout.
    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_timeout = 1'b0;
        if (!enable) begin
            w_next = WAIT_FIRST;
        end else begin
            case (r_state)
                WAIT_FIRST: if (w_rise) w_next = MEASURE;
                MEASURE: begin
                    if (w_rise) begin
                        w_capture = 1'b1;
                    end else if (r_cnt == L_TIMEOUT) begin
                        w_timeout = 1'b1;
                        w_next    = WAIT_FIRST;
                    end
                end
                default: w_next = WAIT_FIRST;
            endcase
        end
    end

    // Counters start at 1 on a rise so the cycle carrying the edge is part of the period.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt        <= '0;
            r_hi_cnt     <= '0;
            r_period     <= '0;
            r_high_time  <= '0;
            r_meas_valid <= 1'b0;
            r_stuck      <= 1'b0;
        end else begin
            r_meas_valid <= 1'b0;
            if (!enable) begin
                r_cnt    <= '0;
                r_hi_cnt <= '0;
            end else if (r_state == WAIT_FIRST) begin
                r_cnt    <= w_rise ? CNT_W'(1) : '0;
                r_hi_cnt <= w_rise ? CNT_W'(1) : '0;
            end else if (w_capture) begin
                r_period     <= r_cnt;
                r_high_time  <= r_hi_cnt;
                r_meas_valid <= 1'b1;
                r_stuck      <= 1'b0;
                r_cnt        <= CNT_W'(1);
                r_hi_cnt     <= CNT_W'(1);
            end else if (w_timeout) begin
                r_stuck  <= 1'b1;
                r_cnt    <= '0;
                r_hi_cnt <= '0;
            end else begin
                r_cnt    <= r_cnt + CNT_W'(1);
                r_hi_cnt <= r_hi_cnt + CNT_W'(w_s);
            end
        end
    end

    assign period     = r_period;
    assign high_time  = r_high_time;
    assign meas_valid = r_meas_valid;
    assign stuck      = r_stuck;
    assign level      = w_s;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: table-driven waveforms plus timeout, enable and reset sequences.
module tb_freq_meter;
    import freq_pkg::*;

    localparam int W       = 16;
    localparam int TIMEOUT = 120;

    logic         clk_in;
    logic         reset_n;
    logic         enable;
    logic         sig_in;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         meas_valid;
    logic         stuck;
    logic         level;
    state_t       dbg_state;

    freq_meter #(.CNT_W(W), .TIMEOUT_CYC(TIMEOUT)) dut (
        .clk_in     (clk_in),
        .reset_n    (reset_n),
        .enable     (enable),
        .sig_in     (sig_in),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .stuck      (stuck),
        .level      (level),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [2*W-1:0] exp_q[$];
    logic [W-1:0] mdl_p = '0;
    logic [W-1:0] mdl_h = '0;
    bit           mon_on = 1'b0;
    bit           chk_stuck0 = 1'b0;
    bit           jit = 1'b0;
    bit           pend = 1'b0;
    logic [W-1:0] pend_p = '0;
    logic [W-1:0] pend_h = '0;

    typedef struct {
        int           h;
        int           l;
        int           n;
        bit           jit;
        logic [W-1:0] exp_p;
        logic [W-1:0] exp_h;
    } vec_t;
    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic set_sig(input logic v);
        int d;
        d = jit ? int'($urandom_range(2, 7)) : 1;
        #(d);
        sig_in = v;
    endtask

    task automatic rise_push();
        if (pend) exp_q.push_back({pend_p, pend_h});
        pend = 1'b0;
        set_sig(1'b1);
    endtask

    task automatic gen_period(input int h, input int l, input logic [W-1:0] ep, input logic [W-1:0] eh);
        rise_push();
        repeat (h) @(posedge clk_in);
        set_sig(1'b0);
        repeat (l) @(posedge clk_in);
        pend   = 1'b1;
        pend_p = ep;
        pend_h = eh;
    endtask

    // scoreboard
    always @(negedge clk_in) begin
        if (!reset_n) begin
            mdl_p <= '0;
            mdl_h <= '0;
        end else if (mon_on) begin
            logic [W-1:0] cur_p;
            logic [W-1:0] cur_h;
            cur_p = mdl_p;
            cur_h = mdl_h;
            if (meas_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got period %0d high %0d expected no strobe at %0t",
                             period, high_time, $time);
                end else begin
                    {cur_p, cur_h} = exp_q.pop_front();
                end
                check("stuck_on_valid", 32'(stuck), 32'd0);
            end
            if (chk_stuck0) check("stuck_low", 32'(stuck), 32'd0);
            check("period", 32'(period), 32'(cur_p));
            check("high_time", 32'(high_time), 32'(cur_h));
            mdl_p <= cur_p;
            mdl_h <= cur_h;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tbl[0] = '{h: 5,  l: 5,  n: 4, jit: 1'b0, exp_p: 16'd10,  exp_h: 16'd5};
        tbl[1] = '{h: 3,  l: 7,  n: 3, jit: 1'b0, exp_p: 16'd10,  exp_h: 16'd3};
        tbl[2] = '{h: 2,  l: 2,  n: 3, jit: 1'b0, exp_p: 16'd4,   exp_h: 16'd2};
        tbl[3] = '{h: 37, l: 63, n: 3, jit: 1'b1, exp_p: 16'd100, exp_h: 16'd37};
        tbl[4] = '{h: 2,  l: 8,  n: 3, jit: 1'b0, exp_p: 16'd10,  exp_h: 16'd2};
        tbl[5] = '{h: 60, l: 60, n: 3, jit: 1'b0, exp_p: 16'd120, exp_h: 16'd60};

        reset_n = 1'b0;
        enable  = 1'b0;
        sig_in  = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_period", 32'(period), 32'd0);
        check("rst_high_time", 32'(high_time), 32'd0);
        check("rst_valid", 32'(meas_valid), 32'd0);
        check("rst_stuck", 32'(stuck), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(WAIT_FIRST));
        @(posedge clk_in);
        #2;
        reset_n = 1'b1;
        enable  = 1'b1;
        repeat (2) @(posedge clk_in);
        mon_on     = 1'b1;
        chk_stuck0 = 1'b1;

        // table-driven waveforms, including the period == timeout collision
        for (int i = 0; i < 6; i++) begin
            jit = tbl[i].jit;
            repeat (tbl[i].n) gen_period(tbl[i].h, tbl[i].l, tbl[i].exp_p, tbl[i].exp_h);
        end
        jit = 1'b0;
        chk_stuck0 = 1'b0;

        // timeout: one edge then held high
        rise_push();
        n = 0;
        while (n < 300) begin
            @(posedge clk_in);
            n++;
            #1;
            if (stuck) break;
        end
        check("stuck_latency", 32'(n), 32'(TIMEOUT + 3));
        check("stuck_level", 32'(level), 32'd1);
        check("stuck_state", 32'(dbg_state), 32'(WAIT_FIRST));
        set_sig(1'b0);
        repeat (5) @(posedge clk_in);
        gen_period(4, 6, 16'd10, 16'd4);
        check("stuck_held", 32'(stuck), 32'd1);
        gen_period(4, 6, 16'd10, 16'd4);
        gen_period(4, 6, 16'd10, 16'd4);
        check("stuck_cleared", 32'(stuck), 32'd0);

        // enable dropped for 3 cycles mid-period
        rise_push();
        repeat (5) @(posedge clk_in);
        #1;
        enable = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        enable = 1'b1;
        check("en_state", 32'(dbg_state), 32'(WAIT_FIRST));
        set_sig(1'b0);
        repeat (4) @(posedge clk_in);
        gen_period(5, 5, 16'd10, 16'd5);
        gen_period(5, 5, 16'd10, 16'd5);
        gen_period(5, 5, 16'd10, 16'd5);

        // asynchronous reset between edges
        rise_push();
        repeat (6) @(posedge clk_in);
        #3;
        reset_n = 1'b0;
        #1;
        check("mid_rst_period", 32'(period), 32'd0);
        check("mid_rst_high_time", 32'(high_time), 32'd0);
        check("mid_rst_valid", 32'(meas_valid), 32'd0);
        check("mid_rst_stuck", 32'(stuck), 32'd0);
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_state", 32'(dbg_state), 32'(WAIT_FIRST));
        check("mid_rst_queue", 32'(exp_q.size()), 32'd0);
        sig_in = 1'b0;
        pend   = 1'b0;
        repeat (2) @(posedge clk_in);
        @(posedge clk_in);
        #2;
        reset_n = 1'b1;
        repeat (3) @(posedge clk_in);
        gen_period(6, 4, 16'd10, 16'd6);
        gen_period(6, 4, 16'd10, 16'd6);
        gen_period(6, 4, 16'd10, 16'd6);
        rise_push();
        repeat (10) @(posedge clk_in);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
